sync_pulse_rx: RTL

//  Receive end of the toggle-level pulse crossing. A source domain flips tog_in once per event.

---
 rtl/sync_pulse_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/sync_pulse_rx.sv
// Destination-side receiver for a toggle-level event crossing: synchronises the source toggle,
// queues detected events in a saturating counter and hands them out on valid/ready with an ack toggle.
module sync_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ack_tog,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic [ARM_W-1:0]       arm_cnt_r;
    logic [CNT_W-1:0]       pending_r;
    logic                   valid_r;
    logic                   ack_r;
    logic                   ovf_r;

    logic                   armed_s;
    logic                   edge_s;
    logic                   acc_s;
    logic [CNT_W-1:0]       pending_nxt_s;
    logic                   ovf_nxt_s;
    logic [ARM_W-1:0]       arm_cnt_nxt_s;

    // Edge detection, gated off until the chain has settled after reset release.
    always_comb begin
        armed_s       = (arm_cnt_r == ARM_DONE);
        edge_s        = armed_s & (sync_r[SYNC_STAGES-1] ^ hist_r);
        acc_s         = valid_r & evt_ready;
        arm_cnt_nxt_s = arm_cnt_r;
        if (!armed_s) begin
            arm_cnt_nxt_s = arm_cnt_r + {{(ARM_W-1){1'b0}}, 1'b1};
        end else begin
            arm_cnt_nxt_s = arm_cnt_r;
        end
    end

    // Pending counter and sticky overflow next-state; the counter saturates in both directions.
    always_comb begin
        pending_nxt_s = pending_r;
        ovf_nxt_s     = ovf_r;
        case ({edge_s, acc_s})
            2'b10: begin
                if (pending_r == PEND_MAX) begin
                    pending_nxt_s = pending_r;
                    ovf_nxt_s     = 1'b1;
                end else begin
                    pending_nxt_s = pending_r + PEND_ONE;
                end
            end
            2'b01: begin
                if (pending_r != {CNT_W{1'b0}}) begin
                    pending_nxt_s = pending_r - PEND_ONE;
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            default: pending_nxt_s = pending_r;
        endcase
        // A drop in the same cycle as a clear must win, so only clear when no drop is happening.
        if (clr_ovf && !(edge_s && !acc_s && (pending_r == PEND_MAX))) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_nxt_s;
        end
    end

    // Synchroniser chain, history flop and arming counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            hist_r    <= 1'b0;
            arm_cnt_r <= {ARM_W{1'b0}};
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], tog_in};
            hist_r    <= sync_r[SYNC_STAGES-1];
            arm_cnt_r <= arm_cnt_nxt_s;
        end
    end

    // Event queue state; valid is registered from the next counter value so it tracks pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
            ack_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            valid_r   <= (pending_nxt_s != {CNT_W{1'b0}});
            ack_r     <= ack_r ^ acc_s;
            ovf_r     <= ovf_nxt_s;
        end
    end

    assign evt_valid = valid_r;
    assign ack_tog   = ack_r;
    assign pending   = pending_r;
    assign overflow  = ovf_r;

endmodule
